// File: rtl/rv_pkg.sv
// rv_pkg: shared helpers and lock-state encoding for the round-robin arbiter stage
package rv_pkg;
  typedef enum logic {RV_ARB_IDLE = 1'b0, RV_ARB_LOCKED = 1'b1} rv_arb_state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/rv_rr_arb_stage_if.sv
// rv_rr_arb_stage_if: N requester streams in, one registered stream out
// RV_ARB_LOCK_EN adds per-requester datain_last for packet lock
interface rv_rr_arb_stage_if import rv_pkg::*; #(parameter int N = 4, parameter int WD = 4);
  localparam int IW = clog2(N);
  logic [N*WD-1:0] datain;
  logic [N-1:0]    datain_val;
  logic [N-1:0]    datain_rdy;
  logic            dataout_rdy;
  logic            dataout_val;
  logic [WD-1:0]   dataout;
  logic [IW-1:0]   dataout_src;
`ifdef RV_ARB_LOCK_EN
  logic [N-1:0]    datain_last;
  modport slave (input datain, datain_val, datain_last, dataout_rdy,
                 output datain_rdy, dataout_val, dataout, dataout_src);
  modport master (output datain, datain_val, datain_last, dataout_rdy,
                  input datain_rdy, dataout_val, dataout, dataout_src);
`else
  modport slave (input datain, datain_val, dataout_rdy,
                 output datain_rdy, dataout_val, dataout, dataout_src);
  modport master (output datain, datain_val, dataout_rdy,
                  input datain_rdy, dataout_val, dataout, dataout_src);
`endif
endinterface

// File: rtl/rr_pick.sv
// rr_pick: rotating priority picker, first set request at or after i_ptr wins
module rr_pick import rv_pkg::*; #(parameter int N = 4) (
  input  logic [N-1:0]          i_req,
  input  logic [clog2(N)-1:0]   i_ptr,
  output logic [clog2(N)-1:0]   o_gnt_idx,
  output logic                  o_any
);
  localparam int IW = clog2(N);
  function automatic int rot(input int p, input int k);
    return (p + k >= N) ? p + k - N : p + k;
  endfunction
  // scan farthest-first so the nearest request from i_ptr is the last to win
  always_comb begin
    o_gnt_idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (i_req[rot(int'(i_ptr), k)]) o_gnt_idx = IW'(rot(int'(i_ptr), k));
  end
  assign o_any = |i_req;
endmodule

// File: rtl/rv_rr_arb_stage.sv
// rv_rr_arb_stage: round-robin merge of N valid/ready streams into one registered stage
// RV_ARB_LOCK_EN holds the grant on one requester until its last beat
module rv_rr_arb_stage import rv_pkg::*; #(parameter int N = 4, parameter int WD = 4) (
  input logic               clk,
  input logic               rst,
  rv_rr_arb_stage_if.slave  bus
);
  localparam int IW = clog2(N);
  logic          r_val;
  logic [WD-1:0] r_data;
  logic [IW-1:0] r_src, r_ptr, w_gnt, w_nxt;
  logic [N-1:0]  w_req;
  logic          w_any, w_st_rdy, w_fire, w_adv;
`ifdef RV_ARB_LOCK_EN
  rv_arb_state_t r_state, w_state_nxt;
  logic [IW-1:0] r_lock, w_lock_nxt;
  // while locked only the owner may win, even when it is idle
  assign w_req = (r_state == RV_ARB_LOCKED) ? bus.datain_val & (N'(1) << r_lock) : bus.datain_val;
  assign w_adv = bus.datain_last[w_gnt];
  always_comb begin
    w_state_nxt = w_fire ? (w_adv ? RV_ARB_IDLE : RV_ARB_LOCKED) : r_state;
    w_lock_nxt  = w_fire ? w_gnt : r_lock;
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= RV_ARB_IDLE;
      r_lock  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_lock  <= w_lock_nxt;
    end
`else
  assign w_req = bus.datain_val;
  assign w_adv = 1'b1;
`endif
  rr_pick #(.N(N)) u_pick (.i_req(w_req), .i_ptr(r_ptr), .o_gnt_idx(w_gnt), .o_any(w_any));
  assign w_st_rdy = bus.dataout_rdy || !r_val;
  assign w_fire   = w_st_rdy && w_any && !rst;
  assign w_nxt    = (w_gnt == IW'(N - 1)) ? '0 : w_gnt + IW'(1);
  assign bus.datain_rdy  = w_fire ? N'(1) << w_gnt : '0;
  assign bus.dataout_val = r_val;
  assign bus.dataout     = r_data;
  assign bus.dataout_src = r_src;
  always_ff @(posedge clk)
    if (rst) begin
      r_val  <= 1'b0;
      r_data <= '0;
      r_src  <= '0;
      r_ptr  <= '0;
    end else if (w_st_rdy) begin
      r_val <= w_any;
      if (w_any) begin
        r_data <= bus.datain[int'(w_gnt)*WD +: WD];
        r_src  <= w_gnt;
        if (w_adv) r_ptr <= w_nxt;
      end
    end
endmodule

// File: tb/tb_rv_rr_arb_stage.sv
// tb_rv_rr_arb_stage: directed checks of the round-robin arbiter stage (N=4 and N=3 instances)
module tb_rv_rr_arb_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;

  rv_rr_arb_stage_if #(.N(4), .WD(4)) b ();
  rv_rr_arb_stage_if #(.N(3), .WD(4)) b3 ();
  rv_rr_arb_stage #(.N(4), .WD(4)) dut (.clk(clk), .rst(rst), .bus(b));
  rv_rr_arb_stage #(.N(3), .WD(4)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    b.datain_val = '0;
    b3.datain_val = '0;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    b.datain = 16'hFEDC;
    b.datain_val = 4'hF;
    b.dataout_rdy = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (b.datain_rdy !== 4'b0000) begin failures++; $display("FAIL reset_rdy got=%b exp=0000", b.datain_rdy); end
      tick;
      checks++;
      if (b.dataout_val !== 1'b0) begin failures++; $display("FAIL reset_val got=%b exp=0", b.dataout_val); end
    end
    checks++;
    if (b.dataout !== 4'h0) begin failures++; $display("FAIL reset_dout got=%h exp=0", b.dataout); end
    checks++;
    if (b.dataout_src !== 2'd0) begin failures++; $display("FAIL reset_src got=%0d exp=0", b.dataout_src); end
    b.datain_val = '0;
    rst = 1'b0;
  endtask

  task automatic test_single;
    b.datain = 16'h0A00;
    b.datain_val = 4'b0100;
    b.dataout_rdy = 1'b1;
    #1;
    checks++;
    if (b.datain_rdy !== 4'b0100) begin failures++; $display("FAIL single_rdy got=%b exp=0100", b.datain_rdy); end
    tick;
    checks++;
    if (b.dataout_val !== 1'b1 || b.dataout !== 4'hA || b.dataout_src !== 2'd2) begin
      failures++; $display("FAIL single_out got=val%b/%h/src%0d exp=val1/a/src2", b.dataout_val, b.dataout, b.dataout_src);
    end
    b.datain_val = '0;
    tick;
    checks++;
    if (b.dataout_val !== 1'b0 || b.dataout !== 4'hA) begin
      failures++; $display("FAIL single_drop got=val%b/%h exp=val0/a", b.dataout_val, b.dataout);
    end
  endtask

  task automatic test_rotate;
    logic [3:0] e;
    do_reset;
    b.datain = 16'h3210;
    b.datain_val = 4'hF;
    b.dataout_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      e = 4'b0001 << (k % 4);
      #1;
      checks++;
      if (b.datain_rdy !== e) begin failures++; $display("FAIL rotate_rdy[%0d] got=%b exp=%b", k, b.datain_rdy, e); end
      tick;
      checks++;
      if (b.dataout_val !== 1'b1 || b.dataout_src !== 2'(k % 4) || b.dataout !== 4'(k % 4)) begin
        failures++; $display("FAIL rotate_out[%0d] got=val%b/src%0d/%h exp=val1/src%0d/%h", k, b.dataout_val, b.dataout_src, b.dataout, k % 4, k % 4);
      end
    end
  endtask

  task automatic test_backpressure;
    b.dataout_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (b.datain_rdy !== 4'b0000) begin failures++; $display("FAIL bp_rdy[%0d] got=%b exp=0000", k, b.datain_rdy); end
      tick;
      checks++;
      if (b.dataout_val !== 1'b1 || b.dataout_src !== 2'd3 || b.dataout !== 4'h3) begin
        failures++; $display("FAIL bp_hold[%0d] got=val%b/src%0d/%h exp=val1/src3/3", k, b.dataout_val, b.dataout_src, b.dataout);
      end
    end
    b.dataout_rdy = 1'b1;
    #1;
    checks++;
    if (b.datain_rdy !== 4'b0001) begin failures++; $display("FAIL bp_release_rdy got=%b exp=0001", b.datain_rdy); end
    tick;
    checks++;
    if (b.dataout_val !== 1'b1 || b.dataout_src !== 2'd0 || b.dataout !== 4'h0) begin
      failures++; $display("FAIL bp_release_out got=val%b/src%0d/%h exp=val1/src0/0", b.dataout_val, b.dataout_src, b.dataout);
    end
  endtask

  task automatic test_wrap;
    do_reset;
    b.datain = 16'h4321;
    b.dataout_rdy = 1'b1;
    b.datain_val = 4'b0100;
    tick;
    b.datain_val = 4'b1010;
    #1;
    checks++;
    if (b.datain_rdy !== 4'b1000) begin failures++; $display("FAIL wrap_rdy0 got=%b exp=1000", b.datain_rdy); end
    tick;
    checks++;
    if (b.dataout_src !== 2'd3 || b.dataout !== 4'h4) begin failures++; $display("FAIL wrap_out0 got=src%0d/%h exp=src3/4", b.dataout_src, b.dataout); end
    #1;
    checks++;
    if (b.datain_rdy !== 4'b0010) begin failures++; $display("FAIL wrap_rdy1 got=%b exp=0010", b.datain_rdy); end
    tick;
    checks++;
    if (b.dataout_src !== 2'd1 || b.dataout !== 4'h2) begin failures++; $display("FAIL wrap_out1 got=src%0d/%h exp=src1/2", b.dataout_src, b.dataout); end
    b.datain_val = 4'hF;
    #1;
    checks++;
    if (b.datain_rdy !== 4'b0100) begin failures++; $display("FAIL wrap_ptr got=%b exp=0100", b.datain_rdy); end
    b.datain_val = '0;
    b3.datain = 12'hCBA;
    b3.dataout_rdy = 1'b1;
    b3.datain_val = 3'b100;
    #1;
    checks++;
    if (b3.datain_rdy !== 3'b100) begin failures++; $display("FAIL n3_rdy0 got=%b exp=100", b3.datain_rdy); end
    tick;
    checks++;
    if (b3.dataout_val !== 1'b1 || b3.dataout_src !== 2'd2 || b3.dataout !== 4'hC) begin
      failures++; $display("FAIL n3_out0 got=val%b/src%0d/%h exp=val1/src2/c", b3.dataout_val, b3.dataout_src, b3.dataout);
    end
    b3.datain_val = 3'b111;
    #1;
    checks++;
    if (b3.datain_rdy !== 3'b001) begin failures++; $display("FAIL n3_wrap_rdy got=%b exp=001", b3.datain_rdy); end
    tick;
    checks++;
    if (b3.dataout_src !== 2'd0 || b3.dataout !== 4'hA) begin failures++; $display("FAIL n3_wrap_out got=src%0d/%h exp=src0/a", b3.dataout_src, b3.dataout); end
    b3.datain_val = '0;
  endtask

  task automatic test_lock;
    int exp_src[4];
`ifdef RV_ARB_LOCK_EN
    exp_src = '{1, 1, 1, 0};
    b.datain_last = 4'b1111;
`else
    exp_src = '{1, 0, 1, 0};
`endif
    do_reset;
    b.datain = 16'h0057;
    b.dataout_rdy = 1'b1;
    b.datain_val = 4'b0001;
    tick;
    b.datain_val = 4'b0011;
    for (int k = 0; k < 4; k++) begin
`ifdef RV_ARB_LOCK_EN
      b.datain_last = {2'b11, k == 2, 1'b1};
`endif
      tick;
      checks++;
      if (b.dataout_val !== 1'b1 || b.dataout_src !== 2'(exp_src[k]) || b.dataout !== (exp_src[k] == 1 ? 4'h5 : 4'h7)) begin
        failures++; $display("FAIL lock_seq[%0d] got=val%b/src%0d/%h exp=val1/src%0d", k, b.dataout_val, b.dataout_src, b.dataout, exp_src[k]);
      end
    end
    b.datain_val = '0;
  endtask

  initial begin
    b.datain = '0;
    b.datain_val = '0;
    b.dataout_rdy = 1'b0;
    b3.datain = '0;
    b3.datain_val = '0;
    b3.dataout_rdy = 1'b1;
`ifdef RV_ARB_LOCK_EN
    b.datain_last = '1;
    b3.datain_last = '1;
`endif
    test_reset;
    test_single;
    test_rotate;
    test_backpressure;
    test_wrap;
    test_lock;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
